// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS GPR file and its write-back scoreboard.
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_ADDR_W = 5;

  typedef logic [MIPS_ADDR_W-1:0] reg_addr_t;
  typedef logic [MIPS_DATA_W-1:0] reg_data_t;

  // r0 is hard-wired to zero and is never tracked as pending.
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/mips_scoreboard.sv
// Write-back scoreboard: one pending bit per GPR plus a registered popcount.
// Next-state order per address: write-back clears, flush clears all, alloc sets.
module mips_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W = MIPS_ADDR_W,
  parameter int NUM_WR = 1
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic                     alloc_vld,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush,
  output logic [(2**ADDR_W)-1:0]   pending,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pending_d;
  logic [DEPTH-1:0] pending_q;
  logic [ADDR_W:0]  pend_cnt_d;
  logic [ADDR_W:0]  pend_cnt_q;

  // Pending next state: clear on write-back, flush, then set on alloc (set wins).
  always_comb begin
    pending_d = pending_q;
    for (int j = 0; j < NUM_WR; j++) begin
      pending_d[waddr[j*ADDR_W +: ADDR_W]] =
        we[j] ? 1'b0 : pending_d[waddr[j*ADDR_W +: ADDR_W]];
    end
    pending_d = flush ? {DEPTH{1'b0}} : pending_d;
    pending_d[alloc_addr] = alloc_vld ? 1'b1 : pending_d[alloc_addr];
    // r0 can never hold a pending producer.
    pending_d[ADDR_W'(REG_ZERO)] = 1'b0;
  end

  // Popcount of the next-state vector so the registered count tracks pending_q.
  always_comb begin
    pend_cnt_d = '0;
    for (int a = 0; a < DEPTH; a++) begin
      pend_cnt_d = pend_cnt_d + {{ADDR_W{1'b0}}, pending_d[a]};
    end
  end

  // Pending vector and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_) begin
      pending_q  <= {DEPTH{1'b0}};
      pend_cnt_q <= {(ADDR_W+1){1'b0}};
    end else begin
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pending  = pending_q;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/mips_regfile_sb.sv
// Multi-port MIPS GPR file with integrated write-back scoreboard.
// Optional feature macro: MIPS_RF_BYPASS_EN enables same-cycle write->read bypass.
module mips_regfile_sb
  import mips_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int ADDR_W = MIPS_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     alloc_vld,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_vec_s;
  logic [ADDR_W-1:0] raddr_s [NUM_RD];
  logic [ADDR_W-1:0] waddr_s [NUM_WR];
  logic [DATA_W-1:0] wdata_s [NUM_WR];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign raddr_s[i] = raddr[i*ADDR_W +: ADDR_W];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
    assign waddr_s[j] = waddr[j*ADDR_W +: ADDR_W];
    assign wdata_s[j] = wdata[j*DATA_W +: DATA_W];
  end

  // Storage next state: apply write ports in ascending order so the highest index wins.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NUM_WR; j++) begin
      mem_d[waddr_s[j]] = (we[j] && (waddr_s[j] != ADDR_W'(REG_ZERO)))
                          ? wdata_s[j] : mem_d[waddr_s[j]];
    end
    mem_d[ADDR_W'(REG_ZERO)] = {DATA_W{1'b0}};
  end

  // Storage array with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= {DATA_W{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports: gated by re, with optional bypass from the winning write port.
  always_comb begin
    rdata = {(NUM_RD*DATA_W){1'b0}};
    rbusy = {NUM_RD{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      if (re[i]) begin
        rdata[i*DATA_W +: DATA_W] = mem_q[raddr_s[i]];
        rbusy[i]                  = pend_vec_s[raddr_s[i]];
`ifdef MIPS_RF_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (we[j] && (waddr_s[j] == raddr_s[i]) && (raddr_s[i] != ADDR_W'(REG_ZERO))) begin
            rdata[i*DATA_W +: DATA_W] = wdata_s[j];
            rbusy[i]                  = alloc_vld && (alloc_addr == raddr_s[i]);
          end else begin
            rbusy[i] = rbusy[i];
          end
        end
`endif
      end else begin
        rdata[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rbusy[i]                  = 1'b0;
      end
    end
  end

  mips_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst_       (rst_),
    .we         (we),
    .waddr      (waddr),
    .alloc_vld  (alloc_vld),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .pending    (pend_vec_s),
    .pend_cnt   (pend_cnt)
  );

endmodule
